// File: rtl/eth_rx_ring_reader.sv
// eth_rx_ring_reader: drains RX ring buffers and re-emits each frame as a byte-wide AXI-Stream
// Ports: clk_int/rst_int clock and async active-high reset; en_i gates new frame starts;
//   nextbuf_i/firstbuf_o producer/consumer ring indices; avail_o ring non-empty; busy_o not idle;
//   len_idx_o/len_i length table lookup; mem_req_o/mem_addr_o/mem_rdata_i packet RAM read port;
//   m_axis_tdata/tvalid/tready/tlast byte stream out.
module eth_rx_ring_reader #(
  parameter int BUF_W = 3,
  parameter int WORD_W = 8,
  parameter int LEN_W = 11
) (
  input  logic                    clk_int,
  input  logic                    rst_int,
  input  logic                    en_i,
  input  logic [BUF_W:0]          nextbuf_i,
  output logic [BUF_W:0]          firstbuf_o,
  output logic                    avail_o,
  output logic                    busy_o,
  output logic [BUF_W-1:0]        len_idx_o,
  input  logic [LEN_W-1:0]        len_i,
  output logic                    mem_req_o,
  output logic [BUF_W+WORD_W-1:0] mem_addr_o,
  input  logic [63:0]             mem_rdata_i,
  output logic [7:0]              m_axis_tdata,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  output logic                    m_axis_tlast
);
  typedef enum logic [1:0] {IDLE, FETCH, WAIT, STREAM} state_t;
  state_t r_state, w_next;
  logic [BUF_W:0] r_first;
  logic [LEN_W-1:0] r_len, r_cnt;
  logic [63:0] r_word;
  logic w_start, w_hs, w_last;
  assign w_start = (r_state == IDLE) && en_i && avail_o;
  // handshake derived from state so the output block does not feed back into itself
  assign w_hs = (r_state == STREAM) && m_axis_tready;
  assign w_last = r_cnt == r_len - LEN_W'(1);
  assign firstbuf_o = r_first;
  assign avail_o = r_first != nextbuf_i;
  assign busy_o = r_state != IDLE;
  assign len_idx_o = r_first[BUF_W-1:0];
  always_comb begin
    w_next = r_state;
    mem_req_o = 1'b0;
    mem_addr_o = '0;
    m_axis_tvalid = 1'b0;
    m_axis_tdata = '0;
    m_axis_tlast = 1'b0;
    case (r_state)
      IDLE: w_next = (w_start && len_i != '0) ? FETCH : IDLE;
      FETCH: begin
        mem_req_o = 1'b1;
        mem_addr_o = {r_first[BUF_W-1:0], r_cnt[3 +: WORD_W]};
        w_next = WAIT;
      end
      WAIT: w_next = STREAM;
      default: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata = r_word[{r_cnt[2:0], 3'b000} +: 8];
        m_axis_tlast = w_last;
        // refill after the last byte of a word unless the frame ends there
        w_next = !w_hs ? STREAM : w_last ? IDLE : (&r_cnt[2:0]) ? FETCH : STREAM;
      end
    endcase
  end
  always_ff @(posedge clk_int or posedge rst_int) begin
    if (rst_int) begin
      r_state <= IDLE;
      r_first <= '0;
      r_len <= '0;
      r_cnt <= '0;
      r_word <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_len <= len_i;
        r_cnt <= '0;
      end
      if (r_state == WAIT) r_word <= mem_rdata_i;
      // zero-length buffers are consumed without emitting a beat
      if ((w_start && len_i == '0) || (w_hs && w_last)) r_first <= r_first + (BUF_W+1)'(1);
      if (w_hs && !w_last) r_cnt <= r_cnt + LEN_W'(1);
    end
  end
endmodule

// File: tb/tb_eth_rx_ring_reader.sv
// tb_eth_rx_ring_reader: directed and randomized checks of the RX ring reader against a frame-level model
module tb_eth_rx_ring_reader;
  logic clk_int = 1'b0;
  logic rst_int = 1'b1;
  logic en_i = 1'b0;
  logic m_axis_tready = 1'b1;
  logic [3:0] nextbuf_i = 4'd0;
  logic [3:0] firstbuf_o;
  logic avail_o, busy_o, mem_req_o, m_axis_tvalid, m_axis_tlast;
  logic [2:0] len_idx_o;
  logic [10:0] len_i, mem_addr_o;
  logic [63:0] mem_rdata_i = '0;
  logic [7:0] m_axis_tdata;
  logic [63:0] mem [2048];
  logic [10:0] len_tab [8];
  logic [8:0] bq [$];
  logic [10:0] aq [$];
  int checks = 0, errors = 0, beats = 0, reqs = 0, frames = 0, gap = 0, gap_at_last = 0, bp = 0, nb = 0;
  logic [10:0] last_addr = '0;
  logic pv = 1'b0, pl = 1'b0;
  logic [7:0] pd = '0;

  eth_rx_ring_reader dut (
    .clk_int(clk_int), .rst_int(rst_int), .en_i(en_i), .nextbuf_i(nextbuf_i),
    .firstbuf_o(firstbuf_o), .avail_o(avail_o), .busy_o(busy_o), .len_idx_o(len_idx_o),
    .len_i(len_i), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_rdata_i(mem_rdata_i),
    .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast)
  );

  always #4 clk_int = ~clk_int;
  assign len_i = len_tab[len_idx_o];
  always @(posedge clk_int) if (mem_req_o) mem_rdata_i <= mem[mem_addr_o];
  always @(posedge clk_int) begin
    #1;
    m_axis_tready = (bp == 0) ? 1'b1 : (bp == 1) ? ~m_axis_tready : 1'($urandom);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic expect_frame(input int b);
    int len;
    logic [63:0] wd;
    len = int'(len_tab[b]);
    for (int i = 0; i < len; i++) begin
      wd = mem[b*256 + i/8];
      bq.push_back({i == len - 1, wd[8*(i%8) +: 8]});
    end
    for (int w = 0; w < (len + 7) / 8; w++) aq.push_back(11'(b*256 + w));
  endtask

  task automatic fill(input int b, input int len, input bit cnt);
    logic [63:0] wd;
    len_tab[b] = 11'(len);
    for (int w = 0; w < 256; w++) begin
      for (int k = 0; k < 8; k++) wd[8*k +: 8] = cnt ? 8'(8*w + k) : 8'($urandom);
      mem[b*256 + w] = wd;
    end
    expect_frame(b);
  endtask

  task automatic wait_idle(input string tag);
    int k;
    for (k = 0; k < 4000; k++) begin
      @(negedge clk_int);
      if (!busy_o && !avail_o) break;
    end
    chk(tag, 64'(k < 4000), 64'd1);
  endtask

  always @(negedge clk_int) begin
    logic [63:0] e;
    if (rst_int) begin
      pv = 1'b0;
      gap = 0;
    end else begin
      if (pv) begin
        chk("hold_valid", 64'(m_axis_tvalid), 64'd1);
        chk("hold_data", 64'(m_axis_tdata), 64'(pd));
        chk("hold_last", 64'(m_axis_tlast), 64'(pl));
      end
      if (mem_req_o) begin
        reqs++;
        last_addr = mem_addr_o;
        if (aq.size() != 0) e = 64'(aq.pop_front()); else e = 64'hdead;
        chk("req_addr", 64'(mem_addr_o), e);
      end
      if (m_axis_tvalid && m_axis_tready) begin
        beats++;
        if (bq.size() != 0) e = 64'(bq.pop_front()); else e = 64'hdead;
        chk("beat", 64'({m_axis_tlast, m_axis_tdata}), e);
        if (m_axis_tlast) begin
          frames++;
          gap_at_last = gap;
        end
        gap = 0;
      end else if (!m_axis_tvalid) gap++;
      pv = m_axis_tvalid && !m_axis_tready;
      pd = m_axis_tdata;
      pl = m_axis_tlast;
    end
  end

  initial begin
    int r0, b0, f0, k, kr, n, len;
    for (int b = 0; b < 8; b++) len_tab[b] = '0;
    en_i = 1'b1;
    repeat (3) @(posedge clk_int);
    @(negedge clk_int);
    chk("rst_first", 64'(firstbuf_o), 64'd0);
    chk("rst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("rst_last", 64'(m_axis_tlast), 64'd0);
    chk("rst_data", 64'(m_axis_tdata), 64'd0);
    chk("rst_req", 64'(mem_req_o), 64'd0);
    chk("rst_addr", 64'(mem_addr_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_avail", 64'(avail_o), 64'd0);
    @(posedge clk_int); #1 rst_int = 1'b0;
    repeat (2) @(posedge clk_int);
    #1;
    // 60-byte counting frame, start latency
    fill(0, 60, 1'b1);
    r0 = reqs; b0 = beats; f0 = frames;
    nb = 1; nextbuf_i = nb[3:0];
    kr = -1;
    for (k = 0; k < 20; k++) begin
      @(negedge clk_int);
      if (k == 0) chk("avail_up", 64'(avail_o), 64'd1);
      if (mem_req_o && kr < 0) kr = k;
      if (m_axis_tvalid) break;
    end
    chk("req_latency", 64'(kr), 64'd1);
    chk("valid_latency", 64'(k), 64'd3);
    wait_idle("idle60");
    chk("first60", 64'(firstbuf_o), 64'd1);
    chk("reqs60", 64'(reqs - r0), 64'd8);
    chk("beats60", 64'(beats - b0), 64'd60);
    chk("frames60", 64'(frames - f0), 64'd1);
    chk("gap60", 64'(gap_at_last), 64'd0);
    // same frame under toggling backpressure
    @(posedge clk_int); #1;
    fill(1, 60, 1'b1);
    r0 = reqs; b0 = beats;
    bp = 1;
    nb = 2; nextbuf_i = nb[3:0];
    wait_idle("idle_bp");
    bp = 0;
    chk("beats_bp", 64'(beats - b0), 64'd60);
    chk("reqs_bp", 64'(reqs - r0), 64'd8);
    chk("first_bp", 64'(firstbuf_o), 64'd2);
    // word-boundary lengths 8 and 9
    @(posedge clk_int); #1;
    fill(2, 8, 1'b0);
    r0 = reqs;
    nb = 3; nextbuf_i = nb[3:0];
    wait_idle("idle8");
    chk("reqs8", 64'(reqs - r0), 64'd1);
    chk("gap8", 64'(gap_at_last), 64'd0);
    @(posedge clk_int); #1;
    fill(3, 9, 1'b0);
    r0 = reqs;
    nb = 4; nextbuf_i = nb[3:0];
    wait_idle("idle9");
    chk("reqs9", 64'(reqs - r0), 64'd2);
    chk("gap9", 64'(gap_at_last), 64'd2);
    chk("first9", 64'(firstbuf_o), 64'd4);
    // randomized backlog with random tready until firstbuf reaches 15
    bp = 2;
    while (nb < 15) begin
      @(posedge clk_int); #1;
      n = $urandom_range(1, (15 - nb > 3) ? 3 : 15 - nb);
      for (int j = 0; j < n; j++) begin
        len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 50);
        fill(nb % 8, len, 1'b0);
        nb++;
      end
      nextbuf_i = nb[3:0];
      wait_idle("idle_rand");
    end
    bp = 0;
    chk("first15", 64'(firstbuf_o), 64'd15);
    // wrap 15 -> 0
    @(posedge clk_int); #1;
    fill(7, 4, 1'b0);
    r0 = reqs;
    nb = 16; nextbuf_i = nb[3:0];
    wait_idle("idle_wrap");
    chk("wrap_addr", 64'(last_addr), 64'h700);
    chk("wrap_reqs", 64'(reqs - r0), 64'd1);
    chk("wrap_first", 64'(firstbuf_o), 64'd0);
    chk("wrap_avail", 64'(avail_o), 64'd0);
    // zero-length skip
    @(posedge clk_int); #1;
    fill(0, 0, 1'b0);
    r0 = reqs; b0 = beats;
    nb = 17; nextbuf_i = nb[3:0];
    @(negedge clk_int);
    chk("skip_before", 64'(firstbuf_o), 64'd0);
    @(negedge clk_int);
    chk("skip_after", 64'(firstbuf_o), 64'd1);
    repeat (5) @(negedge clk_int);
    chk("skip_reqs", 64'(reqs - r0), 64'd0);
    chk("skip_beats", 64'(beats - b0), 64'd0);
    chk("skip_busy", 64'(busy_o), 64'd0);
    // en_i dropped mid-frame with a 3-frame backlog
    @(posedge clk_int); #1;
    fill(1, 30, 1'b0);
    fill(2, 30, 1'b0);
    fill(3, 30, 1'b0);
    b0 = beats; f0 = frames;
    nb = 20; nextbuf_i = nb[3:0];
    for (k = 0; k < 500; k++) begin
      @(negedge clk_int);
      if (beats - b0 >= 10) break;
    end
    chk("en_reach10", 64'(k < 500), 64'd1);
    en_i = 1'b0;
    for (k = 0; k < 500; k++) begin
      @(negedge clk_int);
      if (frames > f0) break;
    end
    chk("en_frame_done", 64'(k < 500), 64'd1);
    r0 = reqs;
    repeat (30) @(negedge clk_int);
    chk("en_no_reqs", 64'(reqs - r0), 64'd0);
    chk("en_first", 64'(firstbuf_o), 64'd2);
    chk("en_busy", 64'(busy_o), 64'd0);
    chk("en_avail", 64'(avail_o), 64'd1);
    en_i = 1'b1;
    wait_idle("idle_en");
    chk("en_first_end", 64'(firstbuf_o), 64'd4);
    chk("en_frames", 64'(frames - f0), 64'd3);
    // reset at byte 20 of a 40-byte frame, then replay it from buffer 0
    @(posedge clk_int); #1;
    fill(4, 40, 1'b0);
    b0 = beats;
    nb = 21; nextbuf_i = nb[3:0];
    for (k = 0; k < 500; k++) begin
      @(negedge clk_int);
      if (beats - b0 >= 20) break;
    end
    chk("rst_reach20", 64'(k < 500), 64'd1);
    rst_int = 1'b1;
    #1;
    chk("midrst_valid", 64'(m_axis_tvalid), 64'd0);
    chk("midrst_first", 64'(firstbuf_o), 64'd0);
    chk("midrst_busy", 64'(busy_o), 64'd0);
    chk("midrst_req", 64'(mem_req_o), 64'd0);
    for (int w = 0; w < 256; w++) mem[w] = mem[4*256 + w];
    len_tab[0] = len_tab[4];
    bq.delete();
    aq.delete();
    expect_frame(0);
    nb = 1; nextbuf_i = nb[3:0];
    repeat (2) @(posedge clk_int);
    #1 rst_int = 1'b0;
    b0 = beats; f0 = frames;
    wait_idle("idle_rst");
    chk("replay_beats", 64'(beats - b0), 64'd40);
    chk("replay_frames", 64'(frames - f0), 64'd1);
    chk("replay_first", 64'(firstbuf_o), 64'd1);
    chk("beats_drained", 64'(bq.size()), 64'd0);
    chk("reqs_drained", 64'(aq.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
